// File: rtl/dcache_if.sv
// CPU-side and memory-side bus of the direct-mapped data cache controller.
// The slave modport is the cache. The master modport is the CPU plus the memory.
interface dcache_if;
  logic        READ;
  logic        WRITE;
  logic [7:0]  ADDRESS;
  logic [7:0]  WRITEDATA;
  logic [7:0]  READDATA;
  logic        BUSYWAIT;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA;
  logic [31:0] MEM_READDATA;
  logic        MEM_BUSYWAIT;

  modport slave (
    input  READ, WRITE, ADDRESS, WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
    output READDATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
  );

  modport master (
    output READ, WRITE, ADDRESS, WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
    input  READDATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
  );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back data cache controller: 8-bit byte address, 4-byte blocks.
// Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
//
// state     | meaning
// S_IDLE    | serve hits combinationally; start a miss
// S_WRITEBACK | write the dirty victim block to memory
// S_FETCH   | read the requested block from memory
// S_UPDATE  | install the fetched block, valid=1, dirty=0
module dcache_ctrl #(
  parameter int INDEX_W  = 3,
  parameter int OFFSET_W = 2
) (
  input  logic CLK,
  input  logic RESET,
  dcache_if.slave bus
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0] HIT_COUNT,
  output logic [15:0] MISS_COUNT
`endif
);

  localparam int TAG_W = 6 - INDEX_W;
  localparam int NSETS = 1 << INDEX_W;

  typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_FETCH, S_UPDATE} state_e;

  state_e             state_q, state_d;
  logic [NSETS-1:0]   valid_q, valid_d;
  logic [NSETS-1:0]   dirty_q, dirty_d;
  logic [TAG_W-1:0]   tag_q  [NSETS];
  logic [TAG_W-1:0]   tag_d  [NSETS];
  logic [31:0]        data_q [NSETS];
  logic [31:0]        data_d [NSETS];

  logic [OFFSET_W-1:0] off;
  logic [INDEX_W-1:0]  idx;
  logic [TAG_W-1:0]    req_tag;
  logic                req;
  logic                hit;

  assign off     = bus.ADDRESS[OFFSET_W-1:0];
  assign idx     = bus.ADDRESS[OFFSET_W +: INDEX_W];
  assign req_tag = bus.ADDRESS[7 -: TAG_W];
  assign req     = bus.READ | bus.WRITE;
  assign hit     = valid_q[idx] && (tag_q[idx] == req_tag);

  always_comb begin
    state_d           = state_q;
    valid_d           = valid_q;
    dirty_d           = dirty_q;
    tag_d             = tag_q;
    data_d            = data_q;
    bus.BUSYWAIT      = 1'b0;
    bus.MEM_READ      = 1'b0;
    bus.MEM_WRITE     = 1'b0;
    bus.MEM_ADDRESS   = '0;
    bus.MEM_WRITEDATA = '0;
    bus.READDATA      = '0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (hit) begin
            // READ and WRITE together resolve as a store.
            if (bus.WRITE) begin
              data_d[idx][{off, 3'b000} +: 8] = bus.WRITEDATA;
              dirty_d[idx]                    = 1'b1;
            end else begin
              bus.READDATA = data_q[idx][{off, 3'b000} +: 8];
            end
          end else begin
            bus.BUSYWAIT = 1'b1;
            state_d      = (valid_q[idx] && dirty_q[idx]) ? S_WRITEBACK : S_FETCH;
          end
        end
      end
      S_WRITEBACK: begin
        bus.BUSYWAIT      = 1'b1;
        bus.MEM_WRITE     = 1'b1;
        bus.MEM_ADDRESS   = {tag_q[idx], idx};
        bus.MEM_WRITEDATA = data_q[idx];
        if (!bus.MEM_BUSYWAIT) state_d = S_FETCH;
      end
      S_FETCH: begin
        bus.BUSYWAIT    = 1'b1;
        bus.MEM_READ    = 1'b1;
        bus.MEM_ADDRESS = {req_tag, idx};
        if (!bus.MEM_BUSYWAIT) state_d = S_UPDATE;
      end
      S_UPDATE: begin
        bus.BUSYWAIT = 1'b1;
        data_d[idx]  = bus.MEM_READDATA;
        tag_d[idx]   = req_tag;
        valid_d[idx] = 1'b1;
        dirty_d[idx] = 1'b0;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= S_IDLE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Tag and data arrays carry no reset; valid gates their use.
  always_ff @(posedge CLK) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

`ifdef DCACHE_STATS_EN
  logic [15:0] hit_count_q, hit_count_d;
  logic [15:0] miss_count_q, miss_count_d;
  logic        after_update_q, after_update_d;

  // The hit that completes a miss right after UPDATE is not a new request.
  always_comb begin
    hit_count_d    = hit_count_q;
    miss_count_d   = miss_count_q;
    after_update_d = (state_q == S_UPDATE);
    if ((state_q == S_IDLE) && req && !after_update_q) begin
      if (hit) begin
        if (hit_count_q != 16'hFFFF) hit_count_d = hit_count_q + 16'd1;
      end else begin
        if (miss_count_q != 16'hFFFF) miss_count_d = miss_count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      hit_count_q    <= '0;
      miss_count_q   <= '0;
      after_update_q <= 1'b0;
    end else begin
      hit_count_q    <= hit_count_d;
      miss_count_q   <= miss_count_d;
      after_update_q <= after_update_d;
    end
  end

  assign HIT_COUNT  = hit_count_q;
  assign MISS_COUNT = miss_count_q;
`endif

endmodule
